// File: rtl/bram_sdp.sv
// Simple dual-port RAM: byte-enabled write port, pipelined read port with valid,
// and a zeroing sweep that owns the write port while busy. The array has no reset.
module bram_sdp #(
    parameter int P_DATA_WIDTH     = 32,
    parameter int P_ADDR_WIDTH     = 8,
    parameter int P_RD_LATENCY     = 1,
    parameter int P_RDW_MODE       = 0,
    parameter int P_CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    output logic                      busy_o,
    input  logic                      wr_en_i,
    input  logic [P_ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [P_DATA_WIDTH/8-1:0] wr_be_i,
    input  logic [P_DATA_WIDTH-1:0]   wr_data_i,
    input  logic                      rd_en_i,
    input  logic [P_ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [P_DATA_WIDTH-1:0]   rd_data_o,
    output logic                      rd_valid_o
);
    localparam int NB    = P_DATA_WIDTH / 8;
    localparam int DEPTH = 1 << P_ADDR_WIDTH;
    localparam logic [P_ADDR_WIDTH:0] CNT_LAST = (P_ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [P_ADDR_WIDTH:0] CNT_ONE  = (P_ADDR_WIDTH+1)'(1);

    if ((P_DATA_WIDTH % 8) != 0 || P_DATA_WIDTH < 8) begin : g_bad_dw
        $error("bram_sdp: P_DATA_WIDTH must be a positive multiple of 8");
    end
    if (P_RD_LATENCY < 1 || P_RD_LATENCY > 3) begin : g_bad_lat
        $error("bram_sdp: P_RD_LATENCY must be 1..3");
    end

    typedef enum logic {IDLE, CLEAR} state_e;
    localparam state_e RST_STATE = (P_CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_e                   state_q, state_d;
    logic [P_ADDR_WIDTH:0]    cnt_q, cnt_d;
    logic                     busy, wr_acc, rd_acc;

    logic [P_DATA_WIDTH-1:0]  mem [DEPTH];
    logic                     mem_we;
    logic [P_ADDR_WIDTH-1:0]  mem_waddr;
    logic [NB-1:0]            mem_be;
    logic [P_DATA_WIDTH-1:0]  mem_wdata;
    logic [P_DATA_WIDTH-1:0]  rd_word;

    logic [P_RD_LATENCY:1]                    vld_pipe_q, vld_pipe_d;
    logic [P_RD_LATENCY:1][P_DATA_WIDTH-1:0]  rd_pipe_q, rd_pipe_d;

    assign busy   = (state_q == CLEAR);
    assign wr_acc = wr_en_i && !busy;
    assign rd_acc = rd_en_i && !busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep takes over the single write port; user writes are simply dropped.
    always_comb begin
        mem_we    = wr_acc;
        mem_waddr = wr_addr_i;
        mem_be    = wr_be_i;
        mem_wdata = wr_data_i;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[P_ADDR_WIDTH-1:0];
            mem_be    = '1;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (mem_be[k]) mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    // Write-first forwarding merges only the enabled bytes over the stored word.
    always_comb begin
        rd_word = mem[rd_addr_i];
        if (P_RDW_MODE != 0 && wr_acc && wr_addr_i == rd_addr_i) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be_i[k]) rd_word[8*k +: 8] = wr_data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        vld_pipe_d    = '0;
        rd_pipe_d     = rd_pipe_q;
        vld_pipe_d[1] = rd_acc;
        if (rd_acc) rd_pipe_d[1] = rd_word;
        for (int k = 2; k <= P_RD_LATENCY; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            if (vld_pipe_q[k-1]) rd_pipe_d[k] = rd_pipe_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            rd_pipe_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            rd_pipe_q  <= rd_pipe_d;
        end
    end

    assign busy_o     = busy;
    assign rd_valid_o = vld_pipe_q[P_RD_LATENCY];
    assign rd_data_o  = rd_pipe_q[P_RD_LATENCY];
endmodule

// File: tb/tb_bram_sdp.sv
// Directed bench for bram_sdp: three instances share stimulus (defaults,
// write-first with latency 3, and no clear on reset).
module tb_bram_sdp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_i = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [7:0]  rd_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;

    logic        busy0, rdv0, busy1, rdv1, busy2, rdv2;
    logic [31:0] rdd0, rdd1, rdd2;

    int n_cmp = 0;
    int n_err = 0;
    int bcnt  = 0;

    always #5 clk = ~clk;

    bram_sdp u0 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .busy_o(busy0),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rdd0), .rd_valid_o(rdv0)
    );

    bram_sdp #(.P_RD_LATENCY(3), .P_RDW_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .busy_o(busy1),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rdd1), .rd_valid_o(rdv1)
    );

    bram_sdp #(.P_CLEAR_ON_RESET(0)) u2 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .busy_o(busy2),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rdd2), .rd_valid_o(rdv2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickb();
        tick();
        if (busy0) bcnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd1);
        chk("rst_busy2", 32'(busy2), 32'd0);
        chk("rst_rdv0", 32'(rdv0), 32'd0);
        chk("rst_rdd0", rdd0, 32'h0);
        chk("rst_rdv2", 32'(rdv2), 32'd0);
        chk("rst_rdd2", rdd2, 32'h0);

        // auto-clear after reset release
        rst_n = 1'b1;
        bcnt = 0;
        while (busy0 && bcnt < 1000) begin bcnt++; tick(); end
        chk("auto_clear_cycles", 32'(bcnt), 32'd256);
        chk("auto_clear_busy1", 32'(busy1), 32'd0);

        rd_en = 1'b1; rd_addr = 8'd0;
        tick(); chk("rd0_vld", 32'(rdv0), 32'd1); chk("rd0_data", rdd0, 32'h0);
        rd_addr = 8'd127;
        tick(); chk("rd127_vld", 32'(rdv0), 32'd1); chk("rd127_data", rdd0, 32'h0);
        rd_addr = 8'd255;
        tick(); chk("rd255_vld", 32'(rdv0), 32'd1); chk("rd255_data", rdd0, 32'h0);
        rd_en = 1'b0;
        tick(); chk("rd_idle_vld", 32'(rdv0), 32'd0);

        // byte enables
        wr(8'h10, 32'hAABBCCDD, 4'hF);
        wr(8'h10, 32'h11223344, 4'h5);
        rd_en = 1'b1; rd_addr = 8'h10;
        tick(); rd_en = 1'b0;
        chk("be_vld0", 32'(rdv0), 32'd1);
        chk("be_data0", rdd0, 32'hAA22CC44);
        tick(); tick();
        chk("be_vld1", 32'(rdv1), 32'd1);
        chk("be_data1", rdd1, 32'hAA22CC44);

        // read during write
        wr(8'h20, 32'h12345678, 4'hF);
        wr_en = 1'b1; wr_addr = 8'h20; wr_data = 32'hFFFFFFFF; wr_be = 4'h3;
        rd_en = 1'b1; rd_addr = 8'h20;
        tick(); wr_en = 1'b0; rd_en = 1'b0;
        chk("rdw_mode0", rdd0, 32'h12345678);
        tick(); tick();
        chk("rdw_mode1_vld", 32'(rdv1), 32'd1);
        chk("rdw_mode1", rdd1, 32'h1234FFFF);
        rd_en = 1'b1; rd_addr = 8'h20;
        tick(); rd_en = 1'b0;
        chk("rdw_after0", rdd0, 32'h1234FFFF);
        tick(); tick();
        chk("rdw_after1", rdd1, 32'h1234FFFF);

        // latency and throughput
        for (int i = 1; i <= 4; i++) wr(8'(i), 32'(i), 4'hF);
        for (int i = 1; i <= 7; i++) begin
            rd_en = (i <= 4);
            if (i <= 4) rd_addr = 8'(i);
            tick();
            chk($sformatf("thr_vld0_%0d", i), 32'(rdv0), (i <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("thr_data0_%0d", i), rdd0, (i <= 4) ? 32'(i) : 32'd4);
            chk($sformatf("thr_vld1_%0d", i), 32'(rdv1), (i >= 3 && i <= 6) ? 32'd1 : 32'd0);
            if (i >= 3) chk($sformatf("thr_data1_%0d", i), rdd1, (i <= 6) ? 32'(i - 2) : 32'd4);
        end
        rd_en = 1'b0;

        // clear interplay
        wr(8'h30, 32'hDEADBEEF, 4'hF);
        clear_i = 1'b1; rd_en = 1'b1; rd_addr = 8'h30;
        tick(); clear_i = 1'b0;
        chk("clr_busy", 32'(busy0), 32'd1);
        chk("clr_rd_vld0", 32'(rdv0), 32'd1);
        chk("clr_rd_data0", rdd0, 32'hDEADBEEF);
        bcnt = 1;
        wr_en = 1'b1; wr_addr = 8'h40; wr_data = 32'h55555555; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'h30;
        tickb(); wr_en = 1'b0; rd_en = 1'b0;
        chk("busy_rd_drop0", 32'(rdv0), 32'd0);
        tickb();
        chk("clr_rd_vld1", 32'(rdv1), 32'd1);
        chk("clr_rd_data1", rdd1, 32'hDEADBEEF);
        tickb();
        chk("busy_rd_drop1", 32'(rdv1), 32'd0);
        repeat (20) tickb();
        clear_i = 1'b1;
        tickb(); clear_i = 1'b0;
        while (busy0 && bcnt < 1000) tickb();
        chk("clear_cycles", 32'(bcnt), 32'd256);
        rd_en = 1'b1; rd_addr = 8'h40;
        tick(); chk("drop_wr_vld", 32'(rdv0), 32'd1); chk("drop_wr_data", rdd0, 32'h0);
        rd_addr = 8'h10;
        tick(); rd_en = 1'b0;
        chk("cleared_data", rdd0, 32'h0);
        tick(); tick();

        // reset with a read in flight
        clear_i = 1'b1; rd_en = 1'b1; rd_addr = 8'h20;
        tick(); clear_i = 1'b0; rd_en = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_inflight_vld1", 32'(rdv1), 32'd0);
        chk("rst_inflight_busy2", 32'(busy2), 32'd0);
        chk("rst_inflight_busy0", 32'(busy0), 32'd1);
        tick();
        chk("rst_inflight_lost1", 32'(rdv1), 32'd0);
        rst_n = 1'b1;
        bcnt = 0;
        while (busy0 && bcnt < 1000) begin bcnt++; tick(); end
        chk("rerun_clear_cycles", 32'(bcnt), 32'd256);

        // reset at sweep count 100
        clear_i = 1'b1;
        tick(); clear_i = 1'b0;
        repeat (100) tick();
        chk("mid_sweep_busy2", 32'(busy2), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy2", 32'(busy2), 32'd0);
        chk("mid_rst_busy0", 32'(busy0), 32'd1);
        chk("mid_rst_vld0", 32'(rdv0), 32'd0);
        tick();
        rst_n = 1'b1;
        bcnt = 0;
        while (busy0 && bcnt < 1000) begin bcnt++; tick(); end
        chk("mid_rst_rerun_cycles", 32'(bcnt), 32'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
